gate_logic_pipe: RTL

GATE_LOGIC_PIPE -- requirements
Module: gate_logic_pipe

---
 rtl/gate_pkg.sv | 13 +
 rtl/gate_logic_core.sv | 42 ++++
 rtl/gate_logic_pipe.sv | 81 ++++++++
 3 files changed

// File: rtl/gate_pkg.sv
// rtl/gate_pkg.sv - shared op encodings for the gate logic pipeline
package gate_pkg;

    localparam logic [2:0] OP_OR   = 3'd0;
    localparam logic [2:0] OP_AND  = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_NOR  = 3'd3;
    localparam logic [2:0] OP_NAND = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;
    localparam logic [2:0] OP_PASS = 3'd6;
    localparam logic [2:0] OP_ZERO = 3'd7;

endpackage

// File: rtl/gate_logic_core.sv
// rtl/gate_logic_core.sv - combinational NINPUTS-wide bitwise reduction
module gate_logic_core
    import gate_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int NINPUTS = 2
) (
    input  logic [2:0]               op,
    input  logic [NINPUTS*WIDTH-1:0] operands,
    output logic [WIDTH-1:0]         result
);

    logic [WIDTH-1:0] or_r;
    logic [WIDTH-1:0] and_r;
    logic [WIDTH-1:0] xor_r;

    always_comb begin
        or_r  = '0;
        and_r = '1;
        xor_r = '0;
        for (int k = 0; k < NINPUTS; k++) begin
            or_r  = or_r  | operands[k*WIDTH +: WIDTH];
            and_r = and_r & operands[k*WIDTH +: WIDTH];
            xor_r = xor_r ^ operands[k*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        result = '0;
        case (op)
            OP_OR:   result = or_r;
            OP_AND:  result = and_r;
            OP_XOR:  result = xor_r;
            OP_NOR:  result = ~or_r;
            OP_NAND: result = ~and_r;
            OP_XNOR: result = ~xor_r;
            OP_PASS: result = operands[WIDTH-1:0];
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/gate_logic_pipe.sv
// rtl/gate_logic_pipe.sv - two-stage valid/ready gate logic pipeline; GATE_LOGIC_PIPE_CNT_EN adds xfer_count
module gate_logic_pipe
    import gate_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int NINPUTS = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [2:0]               op,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NINPUTS*WIDTH-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [2:0]               out_op
`ifdef GATE_LOGIC_PIPE_CNT_EN
    ,
    output logic [15:0]              xfer_count
`endif
);

    logic                     s1_valid;
    logic [NINPUTS*WIDTH-1:0] s1_data;
    logic [2:0]               s1_op;
    logic [WIDTH-1:0]         core_result;
    logic                     s2_free;
    logic                     s1_free;

    // A stage can take new data when empty or when its current occupant leaves this edge.
    assign s2_free  = !out_valid || out_ready;
    assign s1_free  = !s1_valid || s2_free;
    assign in_ready = !reset && s1_free;

    gate_logic_core #(
        .WIDTH   (WIDTH),
        .NINPUTS (NINPUTS)
    ) u_core (
        .op       (s1_op),
        .operands (s1_data),
        .result   (core_result)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_data   <= '0;
            s1_op     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_op    <= '0;
        end else begin
            if (s1_free) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_data <= in_data;
                    s1_op   <= op;
                end
            end
            if (s2_free) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_data <= core_result;
                    out_op   <= s1_op;
                end
            end
        end
    end

`ifdef GATE_LOGIC_PIPE_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xfer_count <= '0;
        end else if (out_valid && out_ready && (xfer_count != 16'hFFFF)) begin
            xfer_count <= xfer_count + 16'd1;
        end
    end
`endif

endmodule
